mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates the single CPU memory port between the instruction-fetch unit and the ALU's data-access path (load/store, push/pop). It sits between those two requesters and the memory interface, and owns the memory strobes. It returns read data and a one-cycle completion pulse to the winning requester; the ALU-side pulse drives the ALU's ValidMemData input. Fairness is round-robin, and a stuck memory is caught by a timeout.

## Interface
- TIMEOUT, 255: maximum ACCESS cycles without MemReady before the access is aborted (≥2).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- FetchReq  in  1  fetch read request; level, held until FetchValid.
- FetchAddr  in  32  fetch address; stable while FetchReq is high.
- FetchGrant  out  1  fetch owns the bus (ACCESS and RESP).
- FetchData  out  32  fetch read data.
- FetchValid  out  1  one-cycle fetch completion pulse.
- AluMemIO  in  2  ALU request: 00 none, 01 read, 10 write, 11 treated as none; held until AluValid.
- AluAddr  in  32  ALU address.
- AluWData  in  32  ALU write data.
- AluGrant  out  1  ALU owns the bus (ACCESS and RESP).
- AluRData  out  32  ALU read data.
- AluValid  out  1  one-cycle ALU completion pulse (read or write).
- MemAddr  out  32  memory address.
- MemWData  out  32  memory write data.
- MemRE  out  1  memory read strobe.
- MemWE  out  1  memory write strobe.
- MemRData  in  32  memory read data; valid when MemReady is high.
- MemReady  in  1  memory completion, sampled during ACCESS only.
- BusError  out  1  one-cycle pulse, coincident with the Valid pulse of a timed-out access.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- All outputs are registered.

**IDLE**
- Samples FetchReq and AluMemIO∈{01,10}.
- With no request, it stays in IDLE.
- With one request, that requester wins.
- With both, the requester that is not LastOwner wins.
- On a win:
  - latch the address (plus AluWData and the direction for the ALU) into MemAddr/MemWData;
  - set MemRE (fetch, or ALU read) or MemWE (ALU write);
  - set the winner's Grant and LastOwner;
  - clear the timeout counter;
  - go to ACCESS.

**ACCESS**
- Strobes, address and Grant are held.
- If MemReady=1:
  - drop the strobes;
  - for a read, load MemRData into the owner's data register;
  - set the owner's Valid;
  - go to RESP.
- Otherwise the counter increments. If the counter reaches TIMEOUT−1:
  - drop the strobes;
  - set Valid and BusError;
  - load 0 into the owner's data register for a read;
  - go to RESP.
- If MemReady and the timeout occur in the same cycle, MemReady wins and BusError stays 0.
- A requester dropping its request during ACCESS does not abort the access; Valid still pulses.

**RESP**
- The Valid/BusError pulse is visible.
- Grant stays high.
- Next state is IDLE, and Valid, BusError and Grant clear.
- A requester must deassert its request (or present its next request) on the edge where it samples Valid=1. IDLE evaluates the new values.

**Other rules**
- The non-owner's request is never dropped. It is served in the next IDLE.
- FetchData and AluRData hold their value until that requester's next read completes. ALU writes leave AluRData unchanged.
- MemAddr and MemWData hold their last value after the access.

**Reset** (synchronous, also mid-access)
- At the next edge: state IDLE; all strobes, Grants, Valids and BusError 0.
- MemAddr, MemWData, FetchData and AluRData are 0; counter 0.
- LastOwner = ALU, so fetch wins the first tie.
- An aborted access produces no Valid.

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: strobes asserted (ACCESS).
- MemReady sampled high in cycle k≥1 → Valid in cycle k+1 (RESP) → IDLE in cycle k+2.
- Minimum: Valid 2 cycles after the request is sampled; a zero-wait-state transaction occupies 3 cycles.
- Back-to-back from the same requester: the next strobe comes 3 cycles after the previous one at zero wait states.
- Timeout: the strobe stays high for exactly TIMEOUT cycles; BusError and Valid follow in the next cycle.
- Exactly one of MemRE/MemWE is high in ACCESS, and both are low in every other state.

## Test plan
- Reset, then fetch read of FetchAddr=0x100, with MemReady tied high and MemRData=0xDEADBEEF → MemRE high in cycle 1 only, FetchValid in cycle 2, FetchData=0xDEADBEEF, BusError=0.
- FetchReq and AluMemIO=01 raised together, each held until its Valid → fetch granted first (LastOwner reset), ALU second; the next tie goes to fetch again, so the two alternate.
- ALU write, AluAddr=0x2000, AluWData=0x12345678, MemReady after 4 wait cycles → MemWE high for 5 cycles, MemWData=0x12345678, AluValid one cycle later, AluRData unchanged.
- TIMEOUT=8, ALU read, MemReady never asserted → MemRE high for 8 cycles, then AluValid=BusError=1 for one cycle with AluRData=0; in a second run, MemReady asserted in the 8th cycle → normal completion, BusError=0.
- rst asserted during ACCESS of a fetch → next edge: MemRE=0, FetchGrant=0, no FetchValid, all data outputs 0; a request after rst drops completes normally.
- AluMemIO=11 with no fetch request → no grant and no strobes, FSM stays IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the single CPU memory port shared by instruction fetch and the ALU.
// All outputs are registered; a stuck access is aborted after TIMEOUT strobe cycles with BusError.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FetchReq,
  input  logic [31:0] FetchAddr,
  output logic        FetchGrant,
  output logic [31:0] FetchData,
  output logic        FetchValid,
  input  logic [1:0]  AluMemIO,
  input  logic [31:0] AluAddr,
  input  logic [31:0] AluWData,
  output logic        AluGrant,
  output logic [31:0] AluRData,
  output logic        AluValid,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemRE,
  output logic        MemWE,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic        BusError
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_alu_q, last_alu_d;
  logic            mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic            fetch_grant_q, fetch_grant_d, alu_grant_q, alu_grant_d;
  logic            fetch_valid_q, fetch_valid_d, alu_valid_q, alu_valid_d;
  logic            bus_error_q, bus_error_d;
  logic [31:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0]     fetch_data_q, fetch_data_d, alu_rdata_q, alu_rdata_d;
  logic            alu_req, pick_alu, timeout;
  logic [31:0]     rd_data;

  assign alu_req  = (AluMemIO == 2'b01) || (AluMemIO == 2'b10);
  // On a tie the requester that did not own the previous access wins.
  assign pick_alu = alu_req && (!FetchReq || !last_alu_q);
  assign timeout  = (cnt_q == CntLast);
  assign rd_data  = MemReady ? MemRData : 32'h0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_alu_d    = last_alu_q;
    mem_re_d      = mem_re_q;
    mem_we_d      = mem_we_q;
    fetch_grant_d = fetch_grant_q;
    alu_grant_d   = alu_grant_q;
    fetch_valid_d = 1'b0;
    alu_valid_d   = 1'b0;
    bus_error_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_data_d  = fetch_data_q;
    alu_rdata_d   = alu_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (FetchReq || alu_req) begin
          state_d       = StAccess;
          cnt_d         = '0;
          last_alu_d    = pick_alu;
          fetch_grant_d = !pick_alu;
          alu_grant_d   = pick_alu;
          mem_re_d      = !pick_alu || (AluMemIO == 2'b01);
          mem_we_d      = pick_alu && (AluMemIO == 2'b10);
          mem_addr_d    = pick_alu ? AluAddr : FetchAddr;
          if (pick_alu) mem_wdata_d = AluWData;
        end
      end
      StAccess: begin
        // MemReady takes priority over a coincident timeout.
        if (MemReady || timeout) begin
          state_d       = StResp;
          mem_re_d      = 1'b0;
          mem_we_d      = 1'b0;
          fetch_valid_d = fetch_grant_q;
          alu_valid_d   = alu_grant_q;
          bus_error_d   = !MemReady;
          if (mem_re_q) begin
            if (alu_grant_q) alu_rdata_d = rd_data;
            else             fetch_data_d = rd_data;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d       = StIdle;
        fetch_grant_d = 1'b0;
        alu_grant_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_alu_q    <= 1'b1;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      fetch_grant_q <= 1'b0;
      alu_grant_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      alu_valid_q   <= 1'b0;
      bus_error_q   <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      fetch_data_q  <= 32'h0;
      alu_rdata_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_alu_q    <= last_alu_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      fetch_grant_q <= fetch_grant_d;
      alu_grant_q   <= alu_grant_d;
      fetch_valid_q <= fetch_valid_d;
      alu_valid_q   <= alu_valid_d;
      bus_error_q   <= bus_error_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_data_q  <= fetch_data_d;
      alu_rdata_q   <= alu_rdata_d;
    end
  end

  assign FetchGrant = fetch_grant_q;
  assign FetchData  = fetch_data_q;
  assign FetchValid = fetch_valid_q;
  assign AluGrant   = alu_grant_q;
  assign AluRData   = alu_rdata_q;
  assign AluValid   = alu_valid_q;
  assign MemAddr    = mem_addr_q;
  assign MemWData   = mem_wdata_q;
  assign MemRE      = mem_re_q;
  assign MemWE      = mem_we_q;
  assign BusError   = bus_error_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of whole transactions, hand sequences for reset and
// illegal ALU codes, then randomized traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned Tmo = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        FetchReq;
  logic [31:0] FetchAddr;
  logic        FetchGrant;
  logic [31:0] FetchData;
  logic        FetchValid;
  logic [1:0]  AluMemIO;
  logic [31:0] AluAddr;
  logic [31:0] AluWData;
  logic        AluGrant;
  logic [31:0] AluRData;
  logic        AluValid;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemRE;
  logic        MemWE;
  logic [31:0] MemRData;
  logic        MemReady;
  logic        BusError;

  mem_bus_arbiter #(.TIMEOUT(Tmo)) dut (
    .clk        (clk),
    .rst        (rst),
    .FetchReq   (FetchReq),
    .FetchAddr  (FetchAddr),
    .FetchGrant (FetchGrant),
    .FetchData  (FetchData),
    .FetchValid (FetchValid),
    .AluMemIO   (AluMemIO),
    .AluAddr    (AluAddr),
    .AluWData   (AluWData),
    .AluGrant   (AluGrant),
    .AluRData   (AluRData),
    .AluValid   (AluValid),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemRE      (MemRE),
    .MemWE      (MemWE),
    .MemRData   (MemRData),
    .MemReady   (MemReady),
    .BusError   (BusError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [1:0]  alu_io;
    logic [31:0] alu_addr;
    logic [31:0] alu_wdata;
    int unsigned wait_cyc;   // MemReady rises in ACCESS cycle wait_cyc+1
    logic [31:0] rdata;
    logic        exp_alu;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    int unsigned exp_cycles;
    logic        exp_err;
    logic [31:0] exp_data;
  } txn_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cur_fetch = 32'h0;
  logic [31:0] cur_alu   = 32'h0;
  logic        last_alu  = 1'b1;
  txn_t        tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] bus();
    return {MemRE, MemWE, FetchGrant, AluGrant, FetchValid, AluValid, BusError};
  endfunction

  // Runs one transaction starting in an IDLE cycle and ends in the following IDLE cycle.
  task automatic run_txn(input txn_t v);
    chk("idle_bus", bus(), 7'h0);
    FetchReq  = v.fetch_req;
    FetchAddr = v.fetch_addr;
    AluMemIO  = v.alu_io;
    AluAddr   = v.alu_addr;
    AluWData  = v.alu_wdata;
    MemReady  = 1'b0;
    MemRData  = $urandom;
    step();
    for (int i = 1; i <= int'(v.exp_cycles); i++) begin
      chk("access_bus", bus(), {v.exp_re, v.exp_we, !v.exp_alu, v.exp_alu, 3'b000});
      chk("access_addr", MemAddr, v.exp_addr);
      if (v.exp_we) chk("access_wdata", MemWData, v.exp_wdata);
      MemReady = (i == int'(v.wait_cyc) + 1);
      MemRData = MemReady ? v.rdata : $urandom;
      step();
    end
    MemReady = 1'b0;
    chk("resp_bus", bus(), {2'b00, !v.exp_alu, v.exp_alu, !v.exp_alu, v.exp_alu, v.exp_err});
    if (v.exp_alu) begin
      chk("resp_alu_data", AluRData, v.exp_data);
      chk("resp_fetch_hold", FetchData, cur_fetch);
      cur_alu  = v.exp_data;
      AluMemIO = 2'b00;
    end else begin
      chk("resp_fetch_data", FetchData, v.exp_data);
      chk("resp_alu_hold", AluRData, cur_alu);
      cur_fetch = v.exp_data;
      FetchReq  = 1'b0;
    end
    last_alu = v.exp_alu;
    step();
    chk("post_bus", bus(), 7'h0);
    chk("post_addr_hold", MemAddr, v.exp_addr);
  endtask

  logic        r_freq;
  logic [31:0] r_faddr;
  logic [1:0]  r_aio;
  logic [31:0] r_aaddr;
  logic [31:0] r_awdata;
  txn_t        v;

  initial begin
    tbl[0] = '{1'b1, 32'h100, 2'b01, 32'h2000, 32'h0, 0, 32'hDEADBEEF,
               1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 32'h0, 2'b01, 32'h2000, 32'h0, 2, 32'hCAFEF00D,
               1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 3, 1'b0, 32'hCAFEF00D};
    tbl[2] = '{1'b1, 32'h104, 2'b01, 32'h2008, 32'h0, 0, 32'h0BADF00D,
               1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 1, 1'b0, 32'h0BADF00D};
    tbl[3] = '{1'b0, 32'h0, 2'b01, 32'h2008, 32'h0, 1, 32'h13579BDF,
               1'b1, 1'b1, 1'b0, 32'h2008, 32'h0, 2, 1'b0, 32'h13579BDF};
    tbl[4] = '{1'b1, 32'h108, 2'b10, 32'h200C, 32'hAAAA5555, 0, 32'h24681357,
               1'b0, 1'b1, 1'b0, 32'h108, 32'h0, 1, 1'b0, 32'h24681357};
    tbl[5] = '{1'b0, 32'h0, 2'b10, 32'h200C, 32'hAAAA5555, 0, 32'hFFFFFFFF,
               1'b1, 1'b0, 1'b1, 32'h200C, 32'hAAAA5555, 1, 1'b0, 32'h13579BDF};
    tbl[6] = '{1'b0, 32'h0, 2'b10, 32'h2000, 32'h12345678, 4, 32'hFFFF0000,
               1'b1, 1'b0, 1'b1, 32'h2000, 32'h12345678, 5, 1'b0, 32'h13579BDF};
    tbl[7] = '{1'b0, 32'h0, 2'b01, 32'h3000, 32'h0, 20, 32'h77777777,
               1'b1, 1'b1, 1'b0, 32'h3000, 32'h0, 8, 1'b1, 32'h0};
    tbl[8] = '{1'b0, 32'h0, 2'b01, 32'h3004, 32'h0, 7, 32'h5A5A5A5A,
               1'b1, 1'b1, 1'b0, 32'h3004, 32'h0, 8, 1'b0, 32'h5A5A5A5A};
    tbl[9] = '{1'b1, 32'h10C, 2'b00, 32'h0, 32'h0, 8, 32'h66666666,
               1'b0, 1'b1, 1'b0, 32'h10C, 32'h0, 8, 1'b1, 32'h0};

    rst = 1'b1; FetchReq = 1'b0; FetchAddr = 32'h0; AluMemIO = 2'b00;
    AluAddr = 32'h0; AluWData = 32'h0; MemRData = 32'h0; MemReady = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_bus", bus(), 7'h0);
    chk("reset_mem", {MemAddr, MemWData}, 64'h0);
    chk("reset_rdata", {FetchData, AluRData}, 64'h0);

    // An ALU code of 11 is not a request.
    AluMemIO = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alu11_idle", bus(), 7'h0);
    end
    AluMemIO = 2'b00;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Reset in the middle of a fetch access.
    FetchReq = 1'b1; FetchAddr = 32'h200; MemReady = 1'b0;
    step();
    chk("rst_mid_pre", bus(), 7'b1010000);
    step();
    rst = 1'b1; FetchReq = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_mid_bus", bus(), 7'h0);
    chk("rst_mid_mem", {MemAddr, MemWData}, 64'h0);
    chk("rst_mid_rdata", {FetchData, AluRData}, 64'h0);
    step();
    chk("rst_mid_after", bus(), 7'h0);
    cur_fetch = 32'h0; cur_alu = 32'h0; last_alu = 1'b1;

    // Tie right after reset: fetch wins even though fetch owned the last access before reset.
    v = '{1'b1, 32'h204, 2'b01, 32'h4000, 32'h0, 0, 32'h31415926,
          1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 1, 1'b0, 32'h31415926};
    run_txn(v);

    r_freq = 1'b0; r_faddr = 32'h0; r_aio = 2'b01; r_aaddr = 32'h4000; r_awdata = 32'h0;
    for (int t = 0; t < 200; t++) begin
      if (!r_freq && $urandom_range(0, 1) == 1) begin
        r_freq  = 1'b1;
        r_faddr = $urandom;
      end
      if (r_aio != 2'b01 && r_aio != 2'b10) begin
        if ($urandom_range(0, 1) == 1) begin
          r_aio    = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
          r_aaddr  = $urandom;
          r_awdata = $urandom;
        end else begin
          r_aio = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        end
      end
      if (!r_freq && r_aio != 2'b01 && r_aio != 2'b10) begin
        FetchReq = 1'b0;
        AluMemIO = r_aio;
        step();
        chk("rnd_idle", bus(), 7'h0);
      end else begin
        v.fetch_req  = r_freq;
        v.fetch_addr = r_faddr;
        v.alu_io     = r_aio;
        v.alu_addr   = r_aaddr;
        v.alu_wdata  = r_awdata;
        v.wait_cyc   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
        v.rdata      = $urandom;
        v.exp_alu    = (r_aio == 2'b01 || r_aio == 2'b10) && (!r_freq || !last_alu);
        v.exp_re     = !v.exp_alu || r_aio == 2'b01;
        v.exp_we     = v.exp_alu && r_aio == 2'b10;
        v.exp_addr   = v.exp_alu ? r_aaddr : r_faddr;
        v.exp_wdata  = r_awdata;
        v.exp_cycles = (v.wait_cyc < Tmo) ? v.wait_cyc + 1 : Tmo;
        v.exp_err    = (v.wait_cyc >= Tmo);
        if (v.exp_we)       v.exp_data = cur_alu;
        else if (v.exp_err) v.exp_data = 32'h0;
        else                v.exp_data = v.rdata;
        run_txn(v);
        if (v.exp_alu) r_aio = 2'b00;
        else           r_freq = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
